qpn_wrr_scheduler: RTL
======================

// Module: qpn_wrr_scheduler
// PURPOSE
// - Weighted round-robin scheduler that shares the single SQ-management QPN output channel between NUM_CHNL requesters.
// - Requesters include doorbell processing, WQE parsing and retry/timer sources.
// - Each accepted QPN is registered in a one-entry output stage, so the block also cuts timing between the requesters and the consumer.
// - Per-channel weights set how many consecutive QPNs a channel may issue before the grant rotates.
// PARAMETERS
// - NUM_CHNL  4   number of requesting channels (2..8)
// - QPN_W     14  QPN width; equals QP_NUM_LOG
// - WGT_W     4   width of each per-channel weight field
// PORTS
// - clk                  in   1               clock
// - rst                  in   1               synchronous reset, active-high
// - chnl_qpn_valid       in   NUM_CHNL        per-channel request valid
// - chnl_qpn_data        in   NUM_CHNL*QPN_W  per-channel QPN; channel i occupies [i*QPN_W +: QPN_W]
// - chnl_qpn_ready       out  NUM_CHNL        per-channel accept; one-hot or zero
// - chnl_weight          in   NUM_CHNL*WGT_W  per-channel burst weight; 0 is treated as 1
// - qpn_valid            out  1               output QPN valid
// - qpn_data             out  QPN_W           output QPN
// - qpn_chnl             out  clog2(NUM_CHNL) source channel of qpn_data
// - qpn_ready            in   1               consumer accept
// BEHAVIOUR
// - Reset values: qpn_valid=0, qpn_data=0, qpn_chnl=0, chnl_qpn_ready=0.
//   Internal state resets to cur_ptr=NUM_CHNL-1 and credit=0, so the first search starts at channel 0.
// - Output stage:
//   - can_load = !qpn_valid | qpn_ready.
//   - A transfer occurs on any channel when valid & ready are both 1. Its QPN and channel index appear on qpn_data/qpn_chnl with qpn_valid=1 on the next cycle (latency 1).
//   - Throughput is 1 QPN/cycle when qpn_ready is held high.
//   - qpn_valid drops only after a qpn_ready handshake with no new accept in the same cycle.
//   - While qpn_valid=1 and qpn_ready=0, qpn_data and qpn_chnl hold stable.
// - Selection, evaluated combinationally each cycle; chnl_qpn_ready is 0 for all channels when can_load=0:
//   - HOLD: chnl_qpn_valid[cur_ptr]=1 and credit!=0. Grant cur_ptr; credit <= credit-1.
//   - ROTATE, otherwise: grant the first valid channel scanning cur_ptr+1, cur_ptr+2, ..., wrapping modulo NUM_CHNL, with cur_ptr itself checked last.
//     Then cur_ptr <= granted channel and credit <= max(weight[g],1)-1.
//   - NONE valid: no grant; cur_ptr and credit unchanged.
// - Credit rules:
//   - Credit is WGT_W bits and never wraps below 0.
//   - If the held channel deasserts valid, its remaining credit is forfeited at the next ROTATE.
// - Weight changes take effect only when a channel is next granted via ROTATE; credit in progress is not reloaded.
// - ready is combinational from valid, cur_ptr, credit and can_load.
// - The ready-to-valid path must not loop: requesters must not make valid depend on ready.
// - Requesters must hold valid and data stable until accepted; the scheduler never drops or duplicates a QPN.
// - Reset mid-operation: the registered QPN is discarded, and requesters re-present their requests after reset.
// TESTING
// - Reset, then ch0..3 all valid with weights {1,1,1,1} and qpn_ready=1 -> grants 0,1,2,3,0,... one per cycle; first qpn_valid appears 1 cycle after the first accept.
// - Weights ch0=3, ch1=1, both always valid, ready=1 -> qpn_chnl sequence 0,0,0,1,0,0,0,1.
// - Weight 0 on ch2 with only ch2 valid -> ch2 is granted every cycle; credit stays 0 and it reloads via ROTATE each cycle.
// - qpn_ready=0 for 5 cycles with QPN 0x1A3 held on the output -> data stable, all chnl_qpn_ready=0; on ready=1, the next QPN is accepted in the same cycle.
// - ch1 holding with credit 2 drops valid; ch3 valid -> ch3 granted next. When ch1 is next granted, it gets a full weight reload.
// - Assert rst while qpn_valid=1 -> the next cycle has qpn_valid=0; the first post-reset grant goes to channel 0 if it is valid.

Source files
------------

// File: rtl/qpn_wrr_scheduler.sv
// Weighted round-robin arbiter feeding one registered QPN output stage.
// Per-channel weights set the burst length before the grant rotates.
module qpn_wrr_scheduler #(
  parameter int NUM_CHNL = 4,
  parameter int QPN_W    = 14,
  parameter int WGT_W    = 4,
  localparam int IDX_W   = (NUM_CHNL > 1) ? $clog2(NUM_CHNL) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CHNL-1:0]       chnl_qpn_valid,
  input  logic [NUM_CHNL*QPN_W-1:0] chnl_qpn_data,
  output logic [NUM_CHNL-1:0]       chnl_qpn_ready,
  input  logic [NUM_CHNL*WGT_W-1:0] chnl_weight,
  output logic                      qpn_valid,
  output logic [QPN_W-1:0]          qpn_data,
  output logic [IDX_W-1:0]          qpn_chnl,
  input  logic                      qpn_ready
);

  logic [IDX_W-1:0] cur_ptr_q, cur_ptr_d;
  logic [WGT_W-1:0] credit_q, credit_d;
  logic             qpn_valid_q, qpn_valid_d;
  logic [QPN_W-1:0] qpn_data_q, qpn_data_d;
  logic [IDX_W-1:0] qpn_chnl_q, qpn_chnl_d;

  logic             can_load;
  logic             hold;
  logic             rot_found;
  logic [IDX_W-1:0] rot_idx;
  logic [IDX_W-1:0] scan_idx;
  logic             any_grant;
  logic [IDX_W-1:0] gnt_idx;
  logic [WGT_W-1:0] rot_wgt;
  logic             accept;

  assign can_load = !qpn_valid_q || qpn_ready;
  assign hold     = chnl_qpn_valid[cur_ptr_q] && (credit_q != '0);

  // Scan cur_ptr+1 .. cur_ptr+NUM_CHNL so the current holder is checked last.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    rot_found = 1'b0;
    rot_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_CHNL; k++) begin
      scan_idx = IDX_W'((int'(cur_ptr_q) + k) % NUM_CHNL);
      if (!rot_found && chnl_qpn_valid[scan_idx]) begin
        rot_found = 1'b1;
        rot_idx   = scan_idx;
      end
    end
  end

  assign any_grant = hold || rot_found;
  assign gnt_idx   = hold ? cur_ptr_q : rot_idx;
  assign rot_wgt   = chnl_weight[int'(rot_idx)*WGT_W +: WGT_W];
  assign accept    = can_load && any_grant;

  assign chnl_qpn_ready = accept ? (NUM_CHNL'(1) << gnt_idx) : '0;

  always_comb begin
    cur_ptr_d   = cur_ptr_q;
    credit_d    = credit_q;
    qpn_valid_d = qpn_valid_q;
    qpn_data_d  = qpn_data_q;
    qpn_chnl_d  = qpn_chnl_q;
    if (accept) begin
      qpn_valid_d = 1'b1;
      qpn_data_d  = chnl_qpn_data[int'(gnt_idx)*QPN_W +: QPN_W];
      qpn_chnl_d  = gnt_idx;
      cur_ptr_d   = gnt_idx;
      // A zero weight behaves as one, i.e. no extra credit after this grant.
      if (hold) credit_d = credit_q - 1'b1;
      else      credit_d = (rot_wgt == '0) ? '0 : rot_wgt - 1'b1;
    end else if (qpn_ready) begin
      qpn_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      cur_ptr_q   <= IDX_W'(NUM_CHNL - 1);
      credit_q    <= '0;
      qpn_valid_q <= 1'b0;
      qpn_data_q  <= '0;
      qpn_chnl_q  <= '0;
    end else begin
      cur_ptr_q   <= cur_ptr_d;
      credit_q    <= credit_d;
      qpn_valid_q <= qpn_valid_d;
      qpn_data_q  <= qpn_data_d;
      qpn_chnl_q  <= qpn_chnl_d;
    end
  end

  assign qpn_valid = qpn_valid_q;
  assign qpn_data  = qpn_data_q;
  assign qpn_chnl  = qpn_chnl_q;

endmodule
